// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks pending destination registers of in-flight
// instructions and blocks issue on RAW, WAW or capacity hazards.
// Optional feature macro: SB_RETIRE_BYPASS_EN (same-cycle write-back bypass
// for the RAW/WAW checks). The default build leaves it undefined.
module hazard_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        IssueValid,
    input  logic [4:0]  IssueRs1,
    input  logic [4:0]  IssueRs2,
    input  logic        IssueUse1,
    input  logic        IssueUse2,
    input  logic        IssueWr,
    input  logic [4:0]  IssueRd,
    input  logic        RetireValid,
    input  logic [4:0]  RetireRd,
    input  logic        Flush,
    output logic        Stall,
    output logic        En,
    output logic [31:0] Pend,
    output logic [2:0]  PendCnt
);

    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 3;

    logic [NREG-1:0] r_pend;
    logic [CW-1:0]   r_cnt;

    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_pend_chk;
    logic [NREG-1:0] w_pend_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_clr;
    logic            w_set;
    logic            w_wr;
    logic            w_raw1;
    logic            w_raw2;
    logic            w_waw;
    logic            w_full;
    logic            w_stall;

    // Effective retire: only a pending, non-zero register is cleared
    always_comb begin
        w_clr      = 1'b0;
        w_clr_mask = '0;
        if (RetireValid && (RetireRd != 5'd0) && r_pend[RetireRd]) begin
            w_clr      = 1'b1;
            w_clr_mask = NREG'(1) << RetireRd;
        end
    end

    // Hazard view of the pending bitmap (optionally minus the retiring register)
    always_comb begin
`ifdef SB_RETIRE_BYPASS_EN
        w_pend_chk = r_pend & ~w_clr_mask;
`else
        w_pend_chk = r_pend;
`endif
    end

    // Stall decision from current inputs and registered state only
    always_comb begin
        w_wr    = IssueWr && (IssueRd != 5'd0);
        w_raw1  = IssueUse1 && (IssueRs1 != 5'd0) && w_pend_chk[IssueRs1];
        w_raw2  = IssueUse2 && (IssueRs2 != 5'd0) && w_pend_chk[IssueRs2];
        w_waw   = w_wr && w_pend_chk[IssueRd];
        w_full  = w_wr && (r_cnt == CW'(MAX_INFLIGHT));
        w_stall = IssueValid && (w_raw1 || w_raw2 || w_waw || w_full);
    end

    assign Stall = w_stall;
    assign En    = ~w_stall;

    // Next pending bitmap and count; set wins over a same-register clear
    always_comb begin
        w_set      = IssueValid && !w_stall && w_wr;
        w_set_mask = '0;
        if (w_set) begin
            w_set_mask = NREG'(1) << IssueRd;
        end
        w_pend_nxt = ((r_pend & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
        w_cnt_nxt  = r_cnt + CW'(w_set) - CW'(w_clr);
    end

    // Pending state registers; flush overrides issue and retire
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else if (Flush) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign Pend    = r_pend;
    assign PendCnt = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// all checked against a set-based reference model of the pending registers.
module tb_hazard_scoreboard;

    localparam int unsigned MAXI = 4;

    logic        Clk;
    logic        Clrn;
    logic        IssueValid;
    logic [4:0]  IssueRs1;
    logic [4:0]  IssueRs2;
    logic        IssueUse1;
    logic        IssueUse2;
    logic        IssueWr;
    logic [4:0]  IssueRd;
    logic        RetireValid;
    logic [4:0]  RetireRd;
    logic        Flush;
    logic        Stall;
    logic        En;
    logic [31:0] Pend;
    logic [2:0]  PendCnt;

    int n_vec = 0;
    int n_err = 0;

    bit   pend_m [32];
    logic obs_stall;

`ifdef SB_RETIRE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    hazard_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
        .Clk        (Clk),
        .Clrn       (Clrn),
        .IssueValid (IssueValid),
        .IssueRs1   (IssueRs1),
        .IssueRs2   (IssueRs2),
        .IssueUse1  (IssueUse1),
        .IssueUse2  (IssueUse2),
        .IssueWr    (IssueWr),
        .IssueRd    (IssueRd),
        .RetireValid(RetireValid),
        .RetireRd   (RetireRd),
        .Flush      (Flush),
        .Stall      (Stall),
        .En         (En),
        .Pend       (Pend),
        .PendCnt    (PendCnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) if (pend_m[i]) c++;
        return c;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = pend_m[i];
        return v;
    endfunction

    // A register blocks the issue if it is outstanding and not being written back now (bypass only)
    function automatic bit busy(input int r, input bit rv, input int rrd);
        if (r == 0) return 1'b0;
        if (BYPASS && rv && rrd == r) return 1'b0;
        return pend_m[r];
    endfunction

    function automatic bit model_stall(input bit iv, input int rs1, input int rs2, input bit u1,
                                       input bit u2, input bit wr, input int rd, input bit rv,
                                       input int rrd);
        bit s;
        if (!iv) return 1'b0;
        s = (u1 && busy(rs1, rv, rrd)) || (u2 && busy(rs2, rv, rrd));
        if (wr && rd != 0 && (busy(rd, rv, rrd) || model_cnt() == int'(MAXI))) s = 1'b1;
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    endtask

    // One clock: drive, check combinational outputs, clock, check registered outputs
    task automatic step(input bit iv, input int rs1, input int rs2, input bit u1, input bit u2,
                        input bit wr, input int rd, input bit rv, input int rrd, input bit fl);
        bit exp_stall;
        @(negedge Clk);
        IssueValid  = iv;
        IssueRs1    = 5'(rs1);
        IssueRs2    = 5'(rs2);
        IssueUse1   = u1;
        IssueUse2   = u2;
        IssueWr     = wr;
        IssueRd     = 5'(rd);
        RetireValid = rv;
        RetireRd    = 5'(rrd);
        Flush       = fl;
        #1;
        exp_stall = model_stall(iv, rs1, rs2, u1, u2, wr, rd, rv, rrd);
        obs_stall = Stall;
        check("stall", 32'(Stall), 32'(exp_stall));
        check("en", 32'(En), 32'(!exp_stall));
        if (fl) begin
            model_clear();
        end else begin
            if (rv && rrd != 0) pend_m[rrd] = 1'b0;
            if (iv && !exp_stall && wr && rd != 0) pend_m[rd] = 1'b1;
        end
        @(posedge Clk);
        #1;
        check("pend", Pend, model_vec());
        check("pendcnt", 32'(PendCnt), 32'(model_cnt()));
    endtask

    task automatic do_flush();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        Clrn = 1'b0; IssueValid = 1'b0; IssueRs1 = '0; IssueRs2 = '0;
        IssueUse1 = 1'b0; IssueUse2 = 1'b0; IssueWr = 1'b0; IssueRd = '0;
        RetireValid = 1'b0; RetireRd = '0; Flush = 1'b0;
        model_clear();
        #12;
        check("rst_pend", Pend, 32'd0);
        check("rst_cnt", 32'(PendCnt), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_en", 32'(En), 32'd1);
        @(negedge Clk);
        Clrn = 1'b1;

        // Write r5, then read r5 -> RAW stall
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("w5_pend", Pend, 32'h20);
        check("w5_cnt", 32'(PendCnt), 32'd1);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        check("raw5_stall", 32'(obs_stall), 32'd1);

        // Read r5 while r5 retires
        step(1, 5, 0, 1, 0, 0, 0, 1, 5, 0);
        check("byp5_stall", 32'(obs_stall), 32'(!BYPASS));
        check("byp5_pend", 32'(Pend[5]), 32'd0);

        // Capacity: r1..r4 pending, r6 blocked until one retires
        do_flush();
        for (int r = 1; r <= 4; r++) step(1, 0, 0, 0, 0, 1, r, 0, 0, 0);
        check("cap_cnt4", 32'(PendCnt), 32'd4);
        step(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check("cap_stall", 32'(obs_stall), 32'd1);
        step(1, 0, 0, 0, 0, 1, 6, 1, 2, 0);
        step(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check("cap_accept", 32'(obs_stall), 32'd0);
        check("cap_cnt_stay", 32'(PendCnt), 32'd4);

        // r0 never pends, never stalls
        do_flush();
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        check("r0_stall", 32'(obs_stall), 32'd0);
        check("r0_pend", Pend, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("r0_ret_cnt", 32'(PendCnt), 32'd0);

        // Write r7 while r7 retires
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        check("w7_pend", 32'(Pend[7]), 32'(BYPASS));
        check("w7_cnt", 32'(PendCnt), 32'(BYPASS));

        // Flush beats a concurrent issue
        do_flush();
        for (int r = 1; r <= 3; r++) step(1, 0, 0, 0, 0, 1, r, 0, 0, 0);
        check("fl_cnt3", 32'(PendCnt), 32'd3);
        step(1, 0, 0, 0, 0, 1, 9, 0, 0, 1);
        check("fl_pend", Pend, 32'd0);
        check("fl_cnt", 32'(PendCnt), 32'd0);

        // Asynchronous reset mid-cycle
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        IssueValid = 1'b0;
        #2;
        Clrn = 1'b0;
        #1;
        check("arst_pend", Pend, 32'd0);
        check("arst_cnt", 32'(PendCnt), 32'd0);
        check("arst_en", 32'(En), 32'd1);
        model_clear();
        @(negedge Clk);
        Clrn = 1'b1;

        // Random traffic over a small register window to provoke hazards
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_INFLIGHT, default 4, giving the maximum number of pending destination registers (legal range 1..7).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
  - Clk  input  1  rising-edge clock
  - Clrn  input  1  asynchronous active-low clear
  - IssueValid  input  1  instruction presented for issue
  - IssueRs1  input  5  source register 1 number
  - IssueRs2  input  5  source register 2 number
  - IssueUse1  input  1  source 1 actually read
  - IssueUse2  input  1  source 2 actually read
  - IssueWr  input  1  instruction writes a register
  - IssueRd  input  5  destination register number
  - RetireValid  input  1  write-back completing this cycle
  - RetireRd  input  5  register being written back
  - Flush  input  1  synchronous clear of all pending state
  - Stall  output  1  combinational; issue blocked this cycle
  - En  output  1  combinational; equal to ~Stall; drives the enable of the 5-bit pipeline destination latches
  - Pend  output  32  registered pending bitmap; bit 0 always 0
  - PendCnt  output  3  registered count of pending registers

Function
REQ-003 Register 0 SHALL never be marked pending; reads of r0 and writes to r0 SHALL never cause a stall or a count change.
REQ-004 RAW hazard: Stall SHALL be 1 when IssueValid=1 and either (IssueUse1=1, IssueRs1!=0, Pend[IssueRs1]=1) or (IssueUse2=1, IssueRs2!=0, Pend[IssueRs2]=1).
REQ-005 WAW hazard: Stall SHALL be 1 when IssueValid=1, IssueWr=1, IssueRd!=0 and Pend[IssueRd]=1.
REQ-006 Capacity: Stall SHALL be 1 when IssueValid=1, IssueWr=1, IssueRd!=0 and PendCnt==MAX_INFLIGHT.
REQ-007 Stall SHALL be 0 whenever IssueValid=0.
REQ-008 An issue SHALL be accepted when IssueValid=1 and Stall=0; if IssueWr=1 and IssueRd!=0, Pend[IssueRd] SHALL set on that clock edge.
REQ-009 On RetireValid=1 with Pend[RetireRd]=1, that bit SHALL clear on the clock edge; a retire of a non-pending register or of r0 SHALL be ignored.
REQ-010 Same-edge set and clear of the same register SHALL leave the bit set (set wins).
REQ-011 PendCnt SHALL equal the population count of Pend after every edge: +1 per accepted set, -1 per effective clear, net 0 when both occur.
REQ-012 Flush=1 SHALL clear Pend and PendCnt on the next edge and SHALL override issue and retire in the same cycle; Stall is still computed from the current (pre-flush) state.
REQ-013 Stall SHALL depend only on the current inputs and on registered state; there SHALL be no combinational path from Stall back into any input.

Reset
REQ-014 Clrn=0 SHALL asynchronously force Pend=0 and PendCnt=0; Stall and En SHALL follow from that state (Stall=0 and En=1 when IssueValid=0).
REQ-015 Deassertion of Clrn SHALL take effect at the next rising Clk edge, with no spurious set or clear of any bit.

Configuration
REQ-016 Macro SB_RETIRE_BYPASS_EN:
  - Defined: a register with RetireValid=1 and RetireRd equal to it in the current cycle SHALL be treated as not pending for the RAW and WAW checks (same-cycle write-back bypass).
  - Undefined: hazard checks SHALL use Pend only, costing one extra stall cycle on each same-cycle retire.

Verification
REQ-017 Reset then issue Rd=5 with IssueWr=1 -> Pend[5]=1, PendCnt=1; next issue Rs1=5, Use1=1 -> Stall=1, En=0.
REQ-018 Pend[5]=1; RetireValid=1, RetireRd=5 concurrent with issue Rs1=5 -> Stall=1 with SB_RETIRE_BYPASS_EN undefined and Stall=0 with it defined; Pend[5]=0 after the edge in both cases.
REQ-019 Four accepted writes to r1..r4 with MAX_INFLIGHT=4 -> PendCnt=4; a fifth write to r6 -> Stall=1; a retire of r2 -> the r6 issue is accepted next cycle and PendCnt stays 4.
REQ-020 Issue a write to r0 and a read of r0 with Pend all zero -> Stall=0, Pend=0, PendCnt=0; a retire of r0 -> no change.
REQ-021 Pend[7]=1; issue a write to r7 in the same cycle as a retire of r7 with bypass defined -> accepted, Pend[7]=1, PendCnt unchanged.
REQ-022 PendCnt=3, then Flush=1 together with IssueValid=1 writing r9 -> Pend=0 and PendCnt=0 after the edge; Clrn pulsed low mid-cycle -> outputs clear immediately without waiting for Clk.
